// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the 32x32 register bank.
// Define REGBANK_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module regbank_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  req_i,
   input  logic [1:0]  we_i,
   input  logic [9:0]  sr1_i,
   input  logic [9:0]  sr2_i,
   input  logic [9:0]  dr_i,
   input  logic [63:0] wdata_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  done_o,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   output logic        busy_o,
   output logic [4:0]  rb_sr1_o,
   output logic [4:0]  rb_sr2_o,
   output logic [4:0]  rb_dr_o,
   output logic [31:0] rb_wdata_o,
   output logic        rb_we_o,
   input  logic [31:0] rb_rdata1_i,
   input  logic [31:0] rb_rdata2_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic [1:0]  gnt_q, done_q;
   logic        busy_q;
   logic [31:0] rdata1_q, rdata2_q;
   logic [4:0]  rb_sr1_q, rb_sr2_q, rb_dr_q;
   logic [31:0] rb_wdata_q;
   logic        rb_we_q;
   logic        win;
`ifdef REGBANK_ARB_FIXED_PRIO_EN
`else
   logic        last_q;
`endif

   // win is the index of the requester granted in IDLE
   always_comb begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
      win = ~req_i[0];
`else
      win = (&req_i) ? ~last_q : ~req_i[0];
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         rb_sr1_q   <= '0;
         rb_sr2_q   <= '0;
         rb_dr_q    <= '0;
         rb_wdata_q <= '0;
         rb_we_q    <= 1'b0;
`ifdef REGBANK_ARB_FIXED_PRIO_EN
`else
         last_q     <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_i) begin
                  gnt_q      <= win ? 2'b10 : 2'b01;
                  busy_q     <= 1'b1;
                  rb_sr1_q   <= win ? sr1_i[9:5] : sr1_i[4:0];
                  rb_sr2_q   <= win ? sr2_i[9:5] : sr2_i[4:0];
                  rb_dr_q    <= win ? dr_i[9:5] : dr_i[4:0];
                  rb_wdata_q <= win ? wdata_i[63:32] : wdata_i[31:0];
                  rb_we_q    <= we_i[win];
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               rb_we_q <= 1'b0;
               if (rb_we_q) begin
                  done_q  <= gnt_q;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= 3'(RD_LAT - 1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // read addresses stay on the bank until the last wait edge
               if (cnt_q == '0) begin
                  rdata1_q <= rb_rdata1_i;
                  rdata2_q <= rb_rdata2_i;
                  done_q   <= gnt_q;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE: begin
               done_q     <= '0;
               gnt_q      <= '0;
               busy_q     <= 1'b0;
               rb_sr1_q   <= '0;
               rb_sr2_q   <= '0;
               rb_dr_q    <= '0;
               rb_wdata_q <= '0;
`ifdef REGBANK_ARB_FIXED_PRIO_EN
`else
               last_q     <= gnt_q[1];
`endif
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;
   assign rdata1_o   = rdata1_q;
   assign rdata2_o   = rdata2_q;
   assign rb_sr1_o   = rb_sr1_q;
   assign rb_sr2_o   = rb_sr2_q;
   assign rb_dr_o    = rb_dr_q;
   assign rb_wdata_o = rb_wdata_q;
   assign rb_we_o    = rb_we_q;

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-requester arbiter and access sequencer for the 32 x 32-bit register bank. It lets the button-driven front-end (requester 0) and the program loader / ALU writeback path (requester 1) share the bank's single write port and dual read ports. Each request is one access: either a write of one register or a read of two registers. The arbiter grants requests round-robin, drives the bank ports, waits out the read latency and returns data with a one-cycle done pulse.

## Interface
- RD_LAT, 1: bank read latency in cycles, from address applied to rb_rdata valid; legal range 1..4.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- req  in  2  request level; bit i belongs to requester i; must be held until done[i].
- we  in  2  1 = write access, 0 = read access; sampled at grant.
- sr1  in  10  two 5-bit read register numbers (bits [4:0] for req 0, [9:5] for req 1).
- sr2  in  10  second read register number, packed the same way.
- dr  in  10  write register number, packed the same way.
- wdata  in  64  write data, [31:0] for req 0, [63:32] for req 1.
- gnt  out  2  one-hot; high from ISSUE through DONE for the granted requester.
- done  out  2  one-cycle pulse when the granted access completes.
- rdata1, rdata2  out  32  read results; valid from the done cycle; held until the next read completes.
- busy  out  1  high in any state other than IDLE.
- rb_sr1, rb_sr2, rb_dr  out  5  bank register addresses.
- rb_wdata  out  32  bank write data.
- rb_we  out  1  bank write enable.
- rb_rdata1, rb_rdata2  in  32  bank read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req bit is high, pick a winner by round-robin (see below), latch its we, sr1, sr2, dr and wdata, set gnt, then go to ISSUE.
- ISSUE: drive the latched fields onto rb_*. For a write, rb_we=1 for exactly this cycle and the next state is DONE. For a read, the next state is WAIT.
- WAIT: hold the read addresses for RD_LAT cycles using a down-counter. rb_rdata1/2 are captured into rdata1/2 on the last WAIT edge, then go to DONE.
- DONE: pulse done[winner], clear gnt, update the last-winner pointer, return to IDLE.
- Round-robin rule: if both requests are high, the requester that did not win last wins. A lone request always wins.
- Register 0 gets no special treatment; it is the bank's concern.
- If req drops mid-transaction, the access still completes and done still pulses. Fields are used as latched at grant; changes after grant are ignored.
- If req[i] is still high in the IDLE cycle after done[i], it is a new request.
- rb_we=0 in every state except ISSUE-with-write. rb_* addresses and data are 0 in IDLE.

## Timing
- Request seen in IDLE at cycle t: ISSUE at t+1.
- Write: rb_we high at t+1; done at t+2.
- Read: WAIT from t+2 to t+1+RD_LAT; done and valid rdata at t+2+RD_LAT. With RD_LAT=1, done is at t+3.
- Back-to-back: after DONE, a pending request is granted at the next IDLE cycle, so minimum spacing is 3 cycles for writes.
- Reset values: state IDLE, gnt=0, done=0, busy=0, rdata1=rdata2=0, rb_*=0, last-winner pointer=1 (requester 0 wins the first tie).
- reset asserted mid-access: the access is abandoned with no done pulse. rb_we drops asynchronously and the bank sees no partial write beyond the already-completed edge.

## Configuration
- REGBANK_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins ties and the last-winner pointer is not used. Requester 1 can starve.
- Undefined (default): round-robin as specified above.

## Test plan
- Single write: req0 we=1 dr=1 wdata=10 at t -> rb_we=1, rb_dr=1, rb_wdata=10 at t+1; done[0] at t+2.
- Read back: req1 we=0 sr1=1 sr2=2 after writes of 10 to reg 1 and 20 to reg 2 -> done[1] at t+3 (RD_LAT=1) with rdata1=10, rdata2=20.
- Tie: both req held high continuously -> grants alternate 0,1,0,1. With REGBANK_ARB_FIXED_PRIO_EN, all four grants go to requester 0.
- Field change after grant: change sr1 from 1 to 2 at t+1 -> rdata1 still returns reg 1's content (10).
- Reset mid-read: reset low during WAIT -> no done pulse, all outputs 0 immediately. Next request after release completes normally.
- RD_LAT=3 build: read request at t -> done at t+5 with correct data; busy high from t+1 to t+5.
